// File: rtl/cpu_control_pkg.sv
// Shared definitions for cpu_control: opcodes, FSM states, write-back codes, IR field positions.
// Latency: n/a (definitions only).
// Backpressure: n/a. CTRL_SINGLE_STEP_EN adds the ST_STEP state used after each retired instruction.
package cpu_control_pkg;

  // Instruction word layout: op[18:15] rk[14:10] ri[9:5] rj[4:0], imm in [7:0]
  localparam int INSTR_W = 19;
  localparam int OP_LSB  = 15;
  localparam int OP_W    = 4;
  localparam int RK_LSB  = 10;
  localparam int RI_LSB  = 5;
  localparam int RJ_LSB  = 0;
  localparam int REG_W   = 5;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef logic [OP_W-1:0] opcode_t;

  // ALU operation codes, shared with the ALU
  localparam opcode_t ALU_ADD  = 4'd0;
  localparam opcode_t ALU_ADDC = 4'd1;
  localparam opcode_t ALU_SUB  = 4'd2;
  localparam opcode_t ALU_SUBC = 4'd3;
  localparam opcode_t ALU_NAND = 4'd4;
  localparam opcode_t ALU_NOR  = 4'd5;
  localparam opcode_t ALU_XOR  = 4'd6;
  localparam opcode_t ALU_XNOR = 4'd7;

  // Instruction opcodes; 0-7 are the ALU codes passed straight through
  localparam opcode_t OP_ADD  = ALU_ADD;
  localparam opcode_t OP_ADDC = ALU_ADDC;
  localparam opcode_t OP_SUB  = ALU_SUB;
  localparam opcode_t OP_SUBC = ALU_SUBC;
  localparam opcode_t OP_NAND = ALU_NAND;
  localparam opcode_t OP_NOR  = ALU_NOR;
  localparam opcode_t OP_XOR  = ALU_XOR;
  localparam opcode_t OP_XNOR = ALU_XNOR;
  localparam opcode_t OP_LDI  = 4'd8;
  localparam opcode_t OP_LD   = 4'd9;
  localparam opcode_t OP_ST   = 4'd10;
  localparam opcode_t OP_JMP  = 4'd11;
  localparam opcode_t OP_JZ   = 4'd12;
  localparam opcode_t OP_JC   = 4'd13;
  localparam opcode_t OP_NOP  = 4'd14;
  localparam opcode_t OP_HALT = 4'd15;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_RAM = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_WAIT  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
`ifdef CTRL_SINGLE_STEP_EN
    , ST_STEP = 3'd5
`endif
  } state_t;

  // State entered once an instruction retires
`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t ST_RETIRE = ST_STEP;
`else
  localparam state_t ST_RETIRE = ST_FETCH;
`endif

endpackage

// File: rtl/ctrl_decode.sv
// Combinational IR decode: register selects, ALU op, write-back source, immediate, next pc.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow ir/pc/flags directly.
module ctrl_decode
  import cpu_control_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [INSTR_W-1:0] ir,
  input  logic [PC_W-1:0]    pc,
  input  logic               flag_z,
  input  logic               flag_c,
  output logic [REG_W-1:0]   ri_sel,
  output logic [REG_W-1:0]   rj_sel,
  output logic [REG_W-1:0]   rk_sel,
  output logic [OP_W-1:0]    alusel,
  output logic [1:0]         wb_sel,
  output logic [IMM_W-1:0]   imm,
  output logic               is_alu,
  output logic               is_ldi,
  output logic               is_ld,
  output logic               is_st,
  output logic               is_halt,
  output logic [PC_W-1:0]    pc_inc,
  output logic [PC_W-1:0]    pc_exec
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  opcode_t         op;
  logic [PC_W-1:0] target;

  assign op     = ir[OP_LSB +: OP_W];
  assign target = ir[PC_W-1:0];
  assign ri_sel = ir[RI_LSB +: REG_W];
  assign rj_sel = ir[RJ_LSB +: REG_W];
  assign rk_sel = ir[RK_LSB +: REG_W];
  assign imm    = ir[IMM_LSB +: IMM_W];
  assign pc_inc = pc + PC_ONE;  // wraps modulo 2^PC_W

  // Opcode classification and branch resolution
  always_comb begin
    is_alu  = ~op[OP_W-1];
    is_ldi  = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_halt = 1'b0;
    alusel  = is_alu ? op : ALU_ADD;
    wb_sel  = WB_ALU;
    pc_exec = pc_inc;
    case (op)
      OP_LDI:  begin is_ldi = 1'b1; wb_sel = WB_IMM; end
      OP_LD:   begin is_ld  = 1'b1; wb_sel = WB_RAM; end
      OP_ST:   is_st = 1'b1;
      OP_JMP:  pc_exec = target;
      OP_JZ:   pc_exec = flag_z ? target : pc_inc;
      OP_JC:   pc_exec = flag_c ? target : pc_inc;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control.sv
// Fetch/decode/sequencing FSM of the 8-bit CPU; holds pc, IR and the C/Z flags (CTRL_SINGLE_STEP_EN adds step gating).
// Latency: 3 cycles for ALU/LDI/jump/NOP (FETCH, WAIT, EXEC), 4+ cycles for LD/ST.
// Backpressure: rom_rd held until rom_valid; RAM strobe held in MEM until ram_ready.
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic [PC_W-1:0]    rom_addr,
  output logic               rom_rd,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               rom_valid,
  output logic [REG_W-1:0]   ri_select,
  output logic [REG_W-1:0]   rj_select,
  output logic [REG_W-1:0]   rk_select,
  output logic               update,
  output logic [OP_W-1:0]    alusel,
  output logic [1:0]         wb_sel,
  output logic [IMM_W-1:0]   imm,
  input  logic               alu_c,
  input  logic               alu_c_update,
  input  logic [7:0]         alu_result,
  output logic               ram_re,
  output logic               ram_we,
  input  logic               ram_ready,
  output logic [PC_W-1:0]    pc,
  output logic               flag_c,
  output logic               flag_z,
  output logic               halted
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_z_q, flag_z_d;

  logic [1:0]         dec_wb_sel;
  logic               is_alu, is_ldi, is_ld, is_st, is_halt;
  logic [PC_W-1:0]    pc_inc, pc_exec;
  logic               in_exec, in_mem;

  ctrl_decode #(.PC_W(PC_W)) u_decode (
    .ir      (ir_q),
    .pc      (pc_q),
    .flag_z  (flag_z_q),
    .flag_c  (flag_c_q),
    .ri_sel  (ri_select),
    .rj_sel  (rj_select),
    .rk_sel  (rk_select),
    .alusel  (alusel),
    .wb_sel  (dec_wb_sel),
    .imm     (imm),
    .is_alu  (is_alu),
    .is_ldi  (is_ldi),
    .is_ld   (is_ld),
    .is_st   (is_st),
    .is_halt (is_halt),
    .pc_inc  (pc_inc),
    .pc_exec (pc_exec)
  );

  assign in_exec  = (state_q == ST_EXEC);
  assign in_mem   = (state_q == ST_MEM);

  // rst gates rom_rd so no fetch is requested while held in reset
  assign rom_rd   = rst & ((state_q == ST_FETCH) | (state_q == ST_WAIT));
  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign ram_re   = is_ld & (in_exec | in_mem);
  assign ram_we   = is_st & (in_exec | in_mem);
  // ram_ready is only honoured in MEM, so a ready seen while the strobe first rises is ignored
  assign update   = (in_exec & (is_alu | is_ldi)) | (in_mem & is_ld & ram_ready);
  assign wb_sel   = update ? dec_wb_sel : WB_ALU;
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;
  assign halted   = (state_q == ST_HALT);

  // Next-state, pc, IR and flag update for the sequencing FSM
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    case (state_q)
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rom_valid) begin
          ir_d    = rom_data;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_halt) begin
          state_d = ST_HALT;
        end else if (is_ld || is_st) begin
          state_d = ST_MEM;
        end else begin
          pc_d    = pc_exec;
          state_d = ST_RETIRE;
        end
        if (is_alu) begin
          flag_z_d = (alu_result == 8'h00);
          if (alu_c_update) flag_c_d = alu_c;
        end
      end
      ST_MEM: begin
        if (ram_ready) begin
          pc_d    = pc_inc;
          state_d = ST_RETIRE;
        end
      end
      ST_HALT: state_d = ST_HALT;
`ifdef CTRL_SINGLE_STEP_EN
      ST_STEP: if (step) state_d = ST_FETCH;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // FSM and architectural state registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: ROM/RAM/ALU stimulus per cycle, register-write scoreboard.
// Latency: n/a.
// Backpressure: ROM valid gaps and delayed RAM ready are driven from the test tasks.
module tb_cpu_control;

  logic        clk;
  logic        rst;
  logic        step;
  logic [7:0]  rom_addr;
  logic        rom_rd;
  logic [18:0] rom_data;
  logic        rom_valid;
  logic [4:0]  ri_select, rj_select, rk_select;
  logic        update;
  logic [3:0]  alusel;
  logic [1:0]  wb_sel;
  logic [7:0]  imm;
  logic        alu_c, alu_c_update;
  logic [7:0]  alu_result;
  logic        ram_re, ram_we, ram_ready;
  logic [7:0]  pc;
  logic        flag_c, flag_z, halted;

  int checks   = 0;
  int failures = 0;

  logic [18:0] prog [0:255];
  int ram_delay = 0;
  int ram_cnt   = 0;

  typedef struct {
    logic [4:0] rk;
    logic [1:0] wb;
    logic [3:0] alu;
    bit         chk_alu;
    logic [7:0] imm;
    bit         chk_imm;
  } exp_t;
  exp_t exp_q[$];

  cpu_control #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef CTRL_SINGLE_STEP_EN
    .step         (step),
`endif
    .rom_addr     (rom_addr),
    .rom_rd       (rom_rd),
    .rom_data     (rom_data),
    .rom_valid    (rom_valid),
    .ri_select    (ri_select),
    .rj_select    (rj_select),
    .rk_select    (rk_select),
    .update       (update),
    .alusel       (alusel),
    .wb_sel       (wb_sel),
    .imm          (imm),
    .alu_c        (alu_c),
    .alu_c_update (alu_c_update),
    .alu_result   (alu_result),
    .ram_re       (ram_re),
    .ram_we       (ram_we),
    .ram_ready    (ram_ready),
    .pc           (pc),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(input logic [3:0] op, input logic [4:0] rk,
                                     input logic [4:0] ri, input logic [4:0] rj);
    return {op, rk, ri, rj};
  endfunction

  function automatic logic [18:0] mki(input logic [3:0] op, input logic [4:0] rk,
                                      input logic [9:0] low);
    return {op, rk, low};
  endfunction

  function automatic void push_exp(input logic [4:0] rk, input logic [1:0] wb,
                                   input logic [3:0] alu, input bit ca,
                                   input logic [7:0] im, input bit ci);
    exp_t e;
    e.rk = rk; e.wb = wb; e.alu = alu; e.chk_alu = ca; e.imm = im; e.chk_imm = ci;
    exp_q.push_back(e);
  endfunction

  // One clock: drive ROM data and the RAM ready model after the falling edge, settle, return
  task automatic tick();
    @(negedge clk);
    rom_data = prog[rom_addr];
    if (ram_re || ram_we) begin
      ram_ready = (ram_cnt >= ram_delay);
      ram_cnt++;
    end else begin
      ram_ready = 1'b0;
      ram_cnt   = 0;
    end
    #1;
  endtask

  task automatic prog_fill();
    for (int i = 0; i < 256; i++) prog[i] = mk(4'd15, 5'd0, 5'd0, 5'd0);
  endtask

  // Hold reset two cycles then release; returns inside the first FETCH cycle
  task automatic release_reset();
    rst = 1'b0;
    rom_valid = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_halt(input int max);
    int n = 0;
    while (halted !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_timeout halted=%b required=1", halted);
    end
  endtask

  // Scoreboard: every update pulse must match the oldest expected register write
  always @(negedge clk) begin
    #2;
    if (update === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_update rk=%0d wb_sel=%0d required=no_update", rk_select, wb_sel);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rk_select !== e.rk || wb_sel !== e.wb || (e.chk_alu && alusel !== e.alu) ||
            (e.chk_imm && imm !== e.imm)) begin
          failures++;
          $display("FAIL sb_write got rk=%0d wb=%0d alu=%0d imm=%h required rk=%0d wb=%0d alu=%0d imm=%h",
                   rk_select, wb_sel, alusel, imm, e.rk, e.wb, e.alu, e.imm);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({rom_rd, update, ram_re, ram_we, halted, flag_c, flag_z} !== 7'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b required=0000000",
               {rom_rd, update, ram_re, ram_we, halted, flag_c, flag_z});
    end
    checks++;
    if (pc !== 8'h00 || rom_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_pc pc=%h rom_addr=%h required=00", pc, rom_addr);
    end
    checks++;
    if ({ri_select, rj_select, rk_select, alusel, wb_sel, imm} !== 29'b0) begin
      failures++;
      $display("FAIL reset_decode got=%h required=0", {ri_select, rj_select, rk_select, alusel, wb_sel, imm});
    end
  endtask

  task automatic test_alu();
    prog_fill();
    prog[0] = mk(4'd0, 5'd2, 5'd0, 5'd1);     // ADD r2 = r0 + r1
    prog[1] = mk(4'd6, 5'd7, 5'd3, 5'd4);     // XOR r7 = r3 ^ r4
    prog[2] = mki(4'd8, 5'd9, 10'h0A5);       // LDI r9 = 0xA5
    alu_result = 8'h05; alu_c = 1'b1; alu_c_update = 1'b0;
    push_exp(5'd2, 2'd0, 4'd0, 1'b1, 8'h00, 1'b0);
    push_exp(5'd7, 2'd0, 4'd6, 1'b1, 8'h00, 1'b0);
    push_exp(5'd9, 2'd1, 4'd0, 1'b0, 8'hA5, 1'b1);
    release_reset();
    checks++;
    if (rom_rd !== 1'b1 || rom_addr !== 8'h00) begin
      failures++;
      $display("FAIL first_fetch rom_rd=%b rom_addr=%h required 1/00", rom_rd, rom_addr);
    end
    tick();
    checks++;
    if (update !== 1'b0 || rom_rd !== 1'b1) begin
      failures++;
      $display("FAIL wait_cycle update=%b rom_rd=%b required 0/1", update, rom_rd);
    end
    tick();
    checks++;
    if (update !== 1'b1 || alusel !== 4'd0 || {ri_select, rj_select, rk_select} !== {5'd0, 5'd1, 5'd2}) begin
      failures++;
      $display("FAIL add_exec update=%b alusel=%0d ri=%0d rj=%0d rk=%0d required 1/0/0/1/2",
               update, alusel, ri_select, rj_select, rk_select);
    end
    tick();
    checks++;
    if (pc !== 8'h01 || flag_z !== 1'b0 || flag_c !== 1'b0 || update !== 1'b0) begin
      failures++;
      $display("FAIL add_retire pc=%h z=%b c=%b update=%b required 01/0/0/0", pc, flag_z, flag_c, update);
    end
    wait_halt(40);
    checks++;
    if (pc !== 8'h03) begin
      failures++;
      $display("FAIL halt_pc pc=%h required=03", pc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL alu_writes_missing left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_flags_jump();
    prog_fill();
    prog[8'h00] = mk(4'd0, 5'd1, 5'd2, 5'd3);   // ADD -> z=1 c=1
    prog[8'h01] = mki(4'd12, 5'd0, 10'h020);    // JZ 0x20 (taken)
    prog[8'h20] = mk(4'd3, 5'd4, 5'd5, 5'd6);   // SUBC -> z=0 c=0
    prog[8'h21] = mki(4'd13, 5'd0, 10'h040);    // JC 0x40 (not taken)
    prog[8'h22] = mki(4'd12, 5'd0, 10'h050);    // JZ 0x50 (not taken)
    prog[8'h23] = mk(4'd0, 5'd8, 5'd1, 5'd1);   // ADD, carry not valid
    alu_result = 8'h00; alu_c = 1'b1; alu_c_update = 1'b1;
    push_exp(5'd1, 2'd0, 4'd0, 1'b1, 8'h00, 1'b0);
    push_exp(5'd4, 2'd0, 4'd3, 1'b1, 8'h00, 1'b0);
    push_exp(5'd8, 2'd0, 4'd0, 1'b1, 8'h00, 1'b0);
    release_reset();
    repeat (3) tick();
    checks++;
    if (flag_z !== 1'b1 || flag_c !== 1'b1 || pc !== 8'h01) begin
      failures++;
      $display("FAIL flags_set z=%b c=%b pc=%h required 1/1/01", flag_z, flag_c, pc);
    end
    alu_result = 8'h01; alu_c = 1'b0;
    repeat (3) tick();
    checks++;
    if (pc !== 8'h20) begin
      failures++;
      $display("FAIL jz_taken pc=%h required=20", pc);
    end
    repeat (3) tick();
    checks++;
    if (pc !== 8'h21 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      failures++;
      $display("FAIL flags_clear pc=%h z=%b c=%b required 21/0/0", pc, flag_z, flag_c);
    end
    repeat (3) tick();
    checks++;
    if (pc !== 8'h22) begin
      failures++;
      $display("FAIL jc_not_taken pc=%h required=22", pc);
    end
    repeat (3) tick();
    checks++;
    if (pc !== 8'h23) begin
      failures++;
      $display("FAIL jz_not_taken pc=%h required=23", pc);
    end
    alu_result = 8'h00; alu_c = 1'b1; alu_c_update = 1'b0;
    repeat (3) tick();
    checks++;
    if (pc !== 8'h24 || flag_c !== 1'b0 || flag_z !== 1'b1) begin
      failures++;
      $display("FAIL carry_hold pc=%h c=%b z=%b required 24/0/1", pc, flag_c, flag_z);
    end
    wait_halt(20);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL flag_writes_missing left=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_ld_st();
    int re_cnt = 0, we_cnt = 0, upd_cnt = 0, upd_bad = 0, ri_bad = 0;
    logic [7:0] imm_exec = 8'h00;
    prog_fill();
    prog[0] = mki(4'd9, 5'd5, 10'h015);         // LD r5 <- RAM[0x15]
    prog[1] = mk(4'd10, 5'd0, 5'd6, 5'd0);      // ST RAM[0x00] <- r6
    alu_c_update = 1'b0;
    ram_delay = 3;
    push_exp(5'd5, 2'd2, 4'd0, 1'b0, 8'h15, 1'b1);
    release_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) imm_exec = imm;
      if (ram_re) re_cnt++;
      if (update) begin
        upd_cnt++;
        if (wb_sel !== 2'd2 || ram_ready !== 1'b1) upd_bad++;
      end else if (wb_sel !== 2'd0) upd_bad++;
    end
    checks++;
    if (re_cnt != 4 || imm_exec !== 8'h15) begin
      failures++;
      $display("FAIL ld_strobe ram_re_cycles=%0d imm=%h required 4/15", re_cnt, imm_exec);
    end
    checks++;
    if (upd_cnt != 1 || upd_bad != 0) begin
      failures++;
      $display("FAIL ld_update pulses=%0d bad=%0d required 1/0", upd_cnt, upd_bad);
    end
    checks++;
    if (pc !== 8'h01 || ram_re !== 1'b0) begin
      failures++;
      $display("FAIL ld_retire pc=%h ram_re=%b required 01/0", pc, ram_re);
    end
    ram_delay = 0;
    upd_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ram_we) begin
        we_cnt++;
        if (ri_select !== 5'd6) ri_bad++;
      end
      if (update) upd_cnt++;
    end
    checks++;
    if (we_cnt != 2 || ri_bad != 0 || upd_cnt != 0) begin
      failures++;
      $display("FAIL st_strobe ram_we_cycles=%0d ri_bad=%0d updates=%0d required 2/0/0", we_cnt, ri_bad, upd_cnt);
    end
    checks++;
    if (pc !== 8'h02 || ram_we !== 1'b0) begin
      failures++;
      $display("FAIL st_retire pc=%h ram_we=%b required 02/0", pc, ram_we);
    end
  endtask

  task automatic test_wrap_halt();
    int rd_cnt = 0;
    prog_fill();
    prog[8'h00] = mki(4'd11, 5'd0, 10'h0FF);    // JMP 0xFF
    prog[8'hFF] = mk(4'd14, 5'd0, 5'd0, 5'd0);  // NOP
    release_reset();
    repeat (3) tick();
    checks++;
    if (pc !== 8'hFF) begin
      failures++;
      $display("FAIL jmp_target pc=%h required=ff", pc);
    end
    prog[8'h00] = mk(4'd15, 5'd0, 5'd0, 5'd0);  // HALT once pc wraps
    repeat (3) tick();
    checks++;
    if (pc !== 8'h00) begin
      failures++;
      $display("FAIL pc_wrap pc=%h required=00", pc);
    end
    repeat (3) tick();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_enter halted=%b required=1", halted);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rom_rd !== 1'b0) rd_cnt++;
    end
    checks++;
    if (rd_cnt != 0 || halted !== 1'b1 || pc !== 8'h00) begin
      failures++;
      $display("FAIL halt_hold fetches=%0d halted=%b pc=%h required 0/1/00", rd_cnt, halted, pc);
    end
  endtask

  task automatic test_reset_mid_st();
    prog_fill();
    prog[0] = mk(4'd14, 5'd0, 5'd0, 5'd0);      // NOP
    prog[1] = mk(4'd10, 5'd0, 5'd3, 5'd0);      // ST, RAM never ready in time
    ram_delay = 20;
    release_reset();
    rom_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (rom_rd !== 1'b1 || pc !== 8'h00 || update !== 1'b0) begin
      failures++;
      $display("FAIL rom_wait rom_rd=%b pc=%h update=%b required 1/00/0", rom_rd, pc, update);
    end
    rom_valid = 1'b1;
    repeat (2) tick();
    checks++;
    if (pc !== 8'h01) begin
      failures++;
      $display("FAIL nop_after_wait pc=%h required=01", pc);
    end
    repeat (3) tick();
    checks++;
    if (ram_we !== 1'b1) begin
      failures++;
      $display("FAIL st_mem_strobe ram_we=%b required=1", ram_we);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || pc !== 8'h00 || update !== 1'b0 || rom_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort ram_we=%b pc=%h update=%b rom_rd=%b required 0/00/0/0",
               ram_we, pc, update, rom_rd);
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (rom_rd !== 1'b1 || rom_addr !== 8'h00) begin
      failures++;
      $display("FAIL refetch rom_rd=%b rom_addr=%h required 1/00", rom_rd, rom_addr);
    end
  endtask

`ifdef CTRL_SINGLE_STEP_EN
  task automatic test_step();
    int rd_cnt;
    prog_fill();
    for (int i = 0; i < 3; i++) prog[i] = mk(4'd14, 5'd0, 5'd0, 5'd0);
    step = 1'b0;
    release_reset();
    checks++;
    if (rom_rd !== 1'b1 || pc !== 8'h00) begin
      failures++;
      $display("FAIL step_first_fetch rom_rd=%b pc=%h required 1/00", rom_rd, pc);
    end
    for (int n = 1; n <= 2; n++) begin
      repeat (3) tick();
      rd_cnt = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (rom_rd !== 1'b0) rd_cnt++;
      end
      checks++;
      if (pc !== 8'(n) || rd_cnt != 0) begin
        failures++;
        $display("FAIL step_idle pc=%h fetches=%0d required %h/0", pc, rd_cnt, 8'(n));
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++;
      if (rom_rd !== 1'b1 || rom_addr !== 8'(n)) begin
        failures++;
        $display("FAIL step_release rom_rd=%b rom_addr=%h required 1/%h", rom_rd, rom_addr, 8'(n));
      end
    end
    repeat (3) tick();
    checks++;
    if (pc !== 8'h03 || rom_rd !== 1'b0) begin
      failures++;
      $display("FAIL step_third pc=%h rom_rd=%b required 03/0", pc, rom_rd);
    end
    step = 1'b1;
    wait_halt(20);
    checks++;
    if (pc !== 8'h03) begin
      failures++;
      $display("FAIL step_halt_pc pc=%h required=03", pc);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; step = 1'b0; rom_valid = 1'b1; rom_data = '0;
    alu_c = 1'b0; alu_c_update = 1'b0; alu_result = 8'h00; ram_ready = 1'b0;
    prog_fill();
    test_reset();
`ifdef CTRL_SINGLE_STEP_EN
    test_step();
`else
    test_alu();
    test_flags_jump();
    test_ld_st();
    test_wrap_halt();
    test_reset_mid_st();
`endif
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
